// File: rtl/des_decrypt_key_sched.sv
// des_decrypt_key_sched: sequential DES round-key generator for the decryption datapath.
// Loads a post-PC-1 key and emits K16..K1 (one per accepted valid/ready beat).
// Optional build macro DES_KEYSCHED_ENC_EN adds an 'encrypt' input that emits K1..K16 instead.

// PC-2 compression permutation: 56-bit CD register to 48-bit round key.
module p_box_56_48 (
  input  logic [55:0] in_i,
  output logic [47:0] out_o
);
  // Standard PC-2 table; entries are 1-based bit positions counted from the MSB.
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign out_o[47 - i] = in_i[56 - PC2[i]];
  end
endmodule

module des_decrypt_key_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [55:0] key_input,
`ifdef DES_KEYSCHED_ENC_EN
  input  logic        encrypt,
`endif
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [47:0] round_key_out,
  output logic [3:0]  seq_idx,
  output logic        last,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  idx_q, idx_d;
  logic        done_q, done_d;
`ifdef DES_KEYSCHED_ENC_EN
  logic        enc_q, enc_d;
`endif

  logic [3:0]  idx_next;
  logic        shift_one;
  logic [55:0] cd_step;

  // Rotate a 28-bit half right by one or two places.
  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  // Rotate a 28-bit half left by one or two places.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  // Single-place steps land on emission indices 1, 8 and 15 in either direction;
  // every other step moves by two places.
  assign idx_next  = idx_q + 4'd1;
  assign shift_one = (idx_next == 4'd1) || (idx_next == 4'd8) || (idx_next == 4'd15);

  // Next CD value for an accepted beat: each half rotates independently.
  always_comb begin
    cd_step = {rotr28(cd_q[55:28], shift_one), rotr28(cd_q[27:0], shift_one)};
`ifdef DES_KEYSCHED_ENC_EN
    if (enc_q) begin
      cd_step = {rotl28(cd_q[55:28], shift_one), rotl28(cd_q[27:0], shift_one)};
    end
`endif
  end

  // FSM next-state: load on start in IDLE, step on each accepted beat in RUN.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef DES_KEYSCHED_ENC_EN
    enc_d   = enc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = 4'd0;
`ifdef DES_KEYSCHED_ENC_EN
          enc_d   = encrypt;
          cd_d    = encrypt ? {rotl28(key_input[55:28], 1'b1), rotl28(key_input[27:0], 1'b1)}
                            : key_input;
`else
          cd_d    = key_input;
`endif
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (idx_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_next;
            cd_d  = cd_step;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any partial sequence without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cd_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef DES_KEYSCHED_ENC_EN
      enc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef DES_KEYSCHED_ENC_EN
      enc_q   <= enc_d;
`endif
    end
  end

  p_box_56_48 u_pc2 (
    .in_i  (cd_q),
    .out_o (round_key_out)
  );

  assign rk_valid = (state_q == RUN);
  assign busy     = (state_q == RUN);
  assign last     = (state_q == RUN) && (idx_q == 4'd15);
  assign seq_idx  = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_des_decrypt_key_sched.sv
// tb_des_decrypt_key_sched: randomized directed bench for des_decrypt_key_sched against a
// forward-schedule DES key model (left shifts, K1..K16, reversed for decryption).
module tb_des_decrypt_key_sched;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [55:0] keyInput;
  logic        rkValid;
  logic        rkReady;
  logic [47:0] roundKey;
  logic [3:0]  seqIdx;
  logic        last;
  logic        busy;
  logic        done;
`ifdef DES_KEYSCHED_ENC_EN
  logic        encrypt;
`endif

  int totalChecks = 0;
  int badChecks   = 0;

  localparam logic [55:0] VEC_KEY = 56'hF0CCAAF556678F;
  localparam logic [47:0] VEC_K16 = 48'hCB3D8B0E17F5;
  localparam logic [47:0] VEC_K1  = 48'h1B02EFFC7072;

  localparam int PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int LEFT_SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [47:0] expKeys [16];

  des_decrypt_key_sched dut (
    .clk           (clk),
    .rst_n         (rstN),
    .start         (start),
    .key_input     (keyInput),
`ifdef DES_KEYSCHED_ENC_EN
    .encrypt       (encrypt),
`endif
    .rk_valid      (rkValid),
    .rk_ready      (rkReady),
    .round_key_out (roundKey),
    .seq_idx       (seqIdx),
    .last          (last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47 - i] = cd[56 - PC2_TABLE[i]];
    return r;
  endfunction

  // Textbook schedule: left-shift C and D, K(r) = PC2(CrDr); emission order depends on mode.
  function automatic void buildKeys(input logic [55:0] key, input bit encMode);
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] k [16];
    c = key[55:28];
    d = key[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < LEFT_SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      k[r] = pc2({c, d});
    end
    for (int n = 0; n < 16; n++) expKeys[n] = encMode ? k[n] : k[15 - n];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    assert (observed === expected) else begin
      badChecks++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [55:0] randKey();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[55:0];
  endfunction

  // One full load/emit cycle; optional start injection and mid-sequence reset abort.
  task automatic applyStimulus(input logic [55:0] key, input bit encMode, input bit randReady,
                               input int injectIdx, input int abortIdx,
                               input logic [47:0] knownFirst, input logic [47:0] knownLast);
    int n;
    int budget;
    buildKeys(key, encMode);
    @(negedge clk);
    start    = 1'b1;
    keyInput = key;
`ifdef DES_KEYSCHED_ENC_EN
    encrypt  = encMode;
`endif
    @(negedge clk);
    start    = 1'b0;
    keyInput = randKey();
    n = 0;
    budget = 0;
    while (n < 16 && budget < 400) begin
      checkOutput("rk_valid", rkValid, 1);
      checkOutput("busy", busy, 1);
      checkOutput("seq_idx", seqIdx, n);
      checkOutput("round_key", roundKey, expKeys[n]);
      checkOutput("last", last, (n == 15));
      checkOutput("done_in_run", done, 0);
      if (n == 0 && knownFirst != 48'h0) checkOutput("known_first", roundKey, knownFirst);
      if (n == 15 && knownLast != 48'h0) checkOutput("known_last", roundKey, knownLast);
      if (n == abortIdx) begin
        rstN = 1'b0;
        #1;
        checkOutput("abort_valid", rkValid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_idx", seqIdx, 0);
        @(negedge clk);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_key", roundKey, 0);
        rstN    = 1'b1;
        rkReady = 1'b0;
        @(negedge clk);
        checkOutput("abort_no_done", done, 0);
        return;
      end
      rkReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n == injectIdx) begin
        start    = 1'b1;
        keyInput = ~key;
      end
      @(negedge clk);
      start = 1'b0;
      if (rkReady) n++;
      budget++;
    end
    if (n < 16) checkOutput("timeout_keys", n, 16);
    checkOutput("done_pulse", done, 1);
    checkOutput("idle_valid", rkValid, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_last", last, 0);
    rkReady = 1'b0;
    @(negedge clk);
    checkOutput("done_clear", done, 0);
    checkOutput("idle_hold", rkValid, 0);
  endtask

  initial begin
    rstN     = 1'b0;
    start    = 1'b0;
    keyInput = '0;
    rkReady  = 1'b0;
`ifdef DES_KEYSCHED_ENC_EN
    encrypt  = 1'b0;
`endif
    $display("[TB] reset checks");
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", rkValid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_last", last, 0);
    checkOutput("rst_idx", seqIdx, 0);
    checkOutput("rst_key", roundKey, 0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("idle_no_start", rkValid, 0);

    $display("[TB] reference vector, ready held high");
    applyStimulus(VEC_KEY, 1'b0, 1'b0, -1, -1, VEC_K16, VEC_K1);

    $display("[TB] reference vector, random ready");
    applyStimulus(VEC_KEY, 1'b0, 1'b1, -1, -1, VEC_K16, VEC_K1);

    $display("[TB] start injected at seq_idx 7");
    applyStimulus(VEC_KEY, 1'b0, 1'b1, 7, -1, VEC_K16, VEC_K1);

    $display("[TB] start injected on final beat");
    applyStimulus(randKey(), 1'b0, 1'b0, 15, -1, 48'h0, 48'h0);

    $display("[TB] reset at seq_idx 5, then fresh load");
    applyStimulus(VEC_KEY, 1'b0, 1'b0, -1, 5, VEC_K16, 48'h0);
    applyStimulus(VEC_KEY, 1'b0, 1'b0, -1, -1, VEC_K16, VEC_K1);

    $display("[TB] random keys");
    for (int t = 0; t < 4; t++) applyStimulus(randKey(), 1'b0, 1'b1, -1, -1, 48'h0, 48'h0);

`ifdef DES_KEYSCHED_ENC_EN
    $display("[TB] encryption order");
    applyStimulus(VEC_KEY, 1'b1, 1'b0, -1, -1, VEC_K1, VEC_K16);
    applyStimulus(randKey(), 1'b1, 1'b1, -1, -1, 48'h0, 48'h0);
    applyStimulus(randKey(), 1'b0, 1'b1, -1, -1, 48'h0, 48'h0);
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/des_decrypt_key_sched.md
# des_decrypt_key_sched

Sequential DES key scheduler for the decryption datapath. It loads a 56-bit post-PC-1 key and emits the sixteen 48-bit round keys in reverse order, K16 first and K1 last. Keys are produced by right-rotating the C/D halves and passing them through the existing `p_box_56_48` (PC-2) instance. It feeds the round engine over a valid/ready handshake, one key per accepted beat.

## Interface
Parameters:
- none. Round count is fixed at 16 and shift schedule is fixed.

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  load request; honoured only in IDLE
- `key_input`  in  56  post-PC-1 key; [55:28]=C0, [27:0]=D0; sampled on accepted `start`
- `rk_valid`  out  1  `round_key_out` holds a valid key
- `rk_ready`  in  1  consumer accepts the key when `rk_valid & rk_ready`
- `round_key_out`  out  48  PC-2 of current CD register
- `seq_idx`  out  4  emission index 0..15 (0 = K16, 15 = K1)
- `last`  out  1  high while `seq_idx==15 & rk_valid`
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse after final key accepted

## Operation
- State: CD register (56b), 4-bit counter `seq_idx`, FSM {IDLE, RUN}.
- IDLE: `rk_valid`=0, `busy`=0. On `start`: CD <= `key_input`, `seq_idx` <= 0, go RUN. No pre-rotation, because C16D16 equals C0D0 (total shift 28).
- RUN: `rk_valid`=1, `busy`=1, `round_key_out` = PC2(CD), combinational from the register.
- Accepted beat with `seq_idx`<15: `seq_idx`++ and CD <= rotr(CD, s[seq_idx+1]). Each 28-bit half rotates independently.
- Right-rotate schedule s[n] for n=1..15: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Cumulative total returns to C1D1 at n=15.
- Accepted beat with `seq_idx`==15: go IDLE, pulse `done` next cycle. CD is left unchanged.
- Stall: while `rk_valid & !rk_ready`, CD, `seq_idx` and outputs hold stable.
- `start` during RUN is ignored, including on the last accepted beat. A new `start` is honoured only once in IDLE, which is the cycle `done` is high or later.
- `rst_n` low at any time, including mid-sequence: immediate return to IDLE with all state cleared. The partial sequence is abandoned and no `done` is issued.

## Timing
- Reset values: `rk_valid`=0, `busy`=0, `done`=0, `last`=0, `seq_idx`=0, CD=0, so `round_key_out`=PC2(0)=0.
- Latency: `start` sampled at edge N, giving `rk_valid`=1 with K16 after edge N.
- Throughput: one key per cycle with `rk_ready` held high. Full sequence takes 16 cycles; `done` asserts in cycle 17 after load.
- `round_key_out` changes only on the edge following an accepted beat.
- Back-to-back sequences: minimum one IDLE cycle between final accept and next load.

## Configuration
- `DES_KEYSCHED_ENC_EN` defined:
  - Adds input `encrypt` (1b), sampled with `start`.
  - `encrypt`=1 loads CD <= rotl(`key_input`,1), then rotates left by 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. This emits K1..K16 and `seq_idx`=0 means K1.
  - `encrypt`=0 gives decryption behaviour exactly as above.
- Undefined: no `encrypt` port; decryption order only.

## Test plan
- Reset with `rst_n`=0 -> all outputs at reset values, `round_key_out`=48'h0.
- Load `key_input`=56'hF0CCAAF556678F with `rk_ready`=1 -> first key 48'hCB3D8B0E17F5 (K16); 16th key 48'h1B02EFFC7072 (K1) with `last`=1; `done` pulses next cycle.
- Same key, `rk_ready` toggled pseudo-randomly -> identical 16-key sequence; outputs stable during every stall.
- `start` pulsed during RUN at `seq_idx`=7 with a different key -> ignored, sequence continues unchanged.
- `rst_n` dropped at `seq_idx`=5 -> `rk_valid`=0 asynchronously, no `done`; a fresh load restarts at K16.
- With `DES_KEYSCHED_ENC_EN`, `encrypt`=1, same key -> first key 48'h1B02EFFC7072, last key 48'hCB3D8B0E17F5.
